// File: rtl/noc_vc_switch_allocator_if.sv
// Bundle between the input blocks, the downstream link and one output-port
// allocator. The allocator attaches through the slave modport; the side that
// drives flits and credit returns uses the master modport.
interface noc_vc_switch_allocator_if #(
    parameter int NUM_INPUTS   = 5,
    parameter int CHANNELS     = 2,
    parameter int FLIT_WIDTH   = 64,
    parameter int CREDIT_DEPTH = 4
);
    localparam int VC_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = $clog2(CREDIT_DEPTH + 1);

    logic [NUM_INPUTS-1:0]            in_valid;
    logic [NUM_INPUTS*VC_W-1:0]       in_vc;
    logic [NUM_INPUTS-1:0]            in_sop;
    logic [NUM_INPUTS-1:0]            in_eop;
    logic [NUM_INPUTS*FLIT_WIDTH-1:0] in_flit;
    logic [NUM_INPUTS-1:0]            in_ready;
    logic                             out_valid;
    logic [VC_W-1:0]                  out_vc;
    logic [FLIT_WIDTH-1:0]            out_flit;
    logic [CHANNELS-1:0]              credit_return;
    logic [CHANNELS*CNT_W-1:0]        credit_count;
    logic [CHANNELS-1:0]              vc_locked;
    logic                             err_credit_ovf;
    logic                             err_protocol;

    modport master (
        output in_valid, in_vc, in_sop, in_eop, in_flit, credit_return,
        input  in_ready, out_valid, out_vc, out_flit, credit_count, vc_locked,
               err_credit_ovf, err_protocol
    );

    modport slave (
        input  in_valid, in_vc, in_sop, in_eop, in_flit, credit_return,
        output in_ready, out_valid, out_vc, out_flit, credit_count, vc_locked,
               err_credit_ovf, err_protocol
    );
endinterface

// File: rtl/noc_vc_switch_allocator.sv
// Per-output-port switch/VC allocator: round-robin arbitration of the input
// blocks onto one link, wormhole ownership per VC, per-VC credit counters and
// a registered output flit stage.
module noc_vc_switch_allocator #(
    parameter int NUM_INPUTS   = 5,
    parameter int CHANNELS     = 2,
    parameter int FLIT_WIDTH   = 64,
    parameter int CREDIT_DEPTH = 4
) (
    input  logic                      noc_clk,
    input  logic                      noc_rst,
    noc_vc_switch_allocator_if.slave  bus
);
    localparam int VC_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = $clog2(CREDIT_DEPTH + 1);
    localparam int IDX_W = $clog2(NUM_INPUTS);
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDIT_DEPTH);

    logic [CNT_W-1:0]      credit_q [CHANNELS];
    logic [CNT_W-1:0]      credit_d [CHANNELS];
    logic [IDX_W-1:0]      owner_q  [CHANNELS];
    logic [IDX_W-1:0]      owner_d  [CHANNELS];
    logic [CHANNELS-1:0]   lock_q, lock_d;
    logic [IDX_W-1:0]      rr_q, rr_d;
    logic                  out_valid_q, out_valid_d;
    logic [VC_W-1:0]       out_vc_q, out_vc_d;
    logic [FLIT_WIDTH-1:0] out_flit_q, out_flit_d;
    logic                  err_ovf_q, err_ovf_d;
    logic                  err_proto_q, err_proto_d;

    logic [NUM_INPUTS-1:0] elig;
    logic [NUM_INPUTS-1:0] viol;
    logic                  gnt_any;
    logic [IDX_W-1:0]      gnt_idx;
    logic [VC_W-1:0]       gnt_vc;
    logic                  gnt_sop, gnt_eop;
    logic [FLIT_WIDTH-1:0] gnt_flit;

    // Per-input eligibility and protocol-violation detection against registered VC state.
    always_comb begin
        elig = '0;
        viol = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (bus.in_vc[i*VC_W +: VC_W] == VC_W'(c)) begin
                    // A head needs an idle VC; body/tail flits only move for the VC owner.
                    elig[i] = bus.in_valid[i] && (credit_q[c] != '0) &&
                              (bus.in_sop[i] ? !lock_q[c]
                                             : (lock_q[c] && (owner_q[c] == IDX_W'(i))));
                    viol[i] = bus.in_valid[i] &&
                              (bus.in_sop[i] ? (lock_q[c] && (owner_q[c] == IDX_W'(i)))
                                             : !lock_q[c]);
                end
            end
        end
    end

    // Round-robin search from the pointer upward with wrap; first eligible input wins.
    always_comb begin
        int idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
            if (!gnt_any && elig[idx] && !noc_rst) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(idx);
            end
        end
    end

    // Select the granted input's flit fields and drive the one-hot ready.
    always_comb begin
        gnt_vc   = bus.in_vc[int'(gnt_idx)*VC_W +: VC_W];
        gnt_flit = bus.in_flit[int'(gnt_idx)*FLIT_WIDTH +: FLIT_WIDTH];
        gnt_sop  = bus.in_sop[gnt_idx];
        gnt_eop  = bus.in_eop[gnt_idx];
        bus.in_ready = '0;
        bus.in_ready[gnt_idx] = gnt_any;
    end

    // Next state for credits, VC locks, round-robin pointer, output stage and error flags.
    always_comb begin
        lock_d      = lock_q;
        rr_d        = rr_q;
        out_valid_d = gnt_any;
        out_vc_d    = out_vc_q;
        out_flit_d  = out_flit_q;
        err_ovf_d   = err_ovf_q;
        err_proto_d = err_proto_q | (|viol);
        for (int c = 0; c < CHANNELS; c++) begin
            credit_d[c] = credit_q[c];
            owner_d[c]  = owner_q[c];
        end

        if (gnt_any) begin
            rr_d       = (int'(gnt_idx) == NUM_INPUTS - 1) ? '0 : gnt_idx + 1'b1;
            out_vc_d   = gnt_vc;
            out_flit_d = gnt_flit;
        end

        for (int c = 0; c < CHANNELS; c++) begin
            // A grant and a return on the same VC cancel out.
            if (gnt_any && (gnt_vc == VC_W'(c)) && !bus.credit_return[c]) begin
                credit_d[c] = credit_q[c] - 1'b1;
            end else if (bus.credit_return[c] && !(gnt_any && (gnt_vc == VC_W'(c)))) begin
                if (credit_q[c] == CREDIT_MAX) err_ovf_d = 1'b1;
                else                           credit_d[c] = credit_q[c] + 1'b1;
            end

            // Single-flit packets (sop && eop) never take the lock.
            if (gnt_any && (gnt_vc == VC_W'(c))) begin
                if (gnt_sop && !gnt_eop) begin
                    lock_d[c]  = 1'b1;
                    owner_d[c] = gnt_idx;
                end else if (!gnt_sop && gnt_eop) begin
                    lock_d[c]  = 1'b0;
                end
            end
        end
    end

    // State registers; reset abandons any in-flight packet immediately.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                credit_q[c] <= CREDIT_MAX;
                owner_q[c]  <= '0;
            end
            lock_q      <= '0;
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_vc_q    <= '0;
            out_flit_q  <= '0;
            err_ovf_q   <= 1'b0;
            err_proto_q <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                credit_q[c] <= credit_d[c];
                owner_q[c]  <= owner_d[c];
            end
            lock_q      <= lock_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_vc_q    <= out_vc_d;
            out_flit_q  <= out_flit_d;
            err_ovf_q   <= err_ovf_d;
            err_proto_q <= err_proto_d;
        end
    end

    // Pack the per-VC credit counters onto the status bus.
    always_comb begin
        bus.credit_count = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            bus.credit_count[c*CNT_W +: CNT_W] = credit_q[c];
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_vc         = out_vc_q;
    assign bus.out_flit       = out_flit_q;
    assign bus.vc_locked      = lock_q;
    assign bus.err_credit_ovf = err_ovf_q;
    assign bus.err_protocol   = err_proto_q;
endmodule

// File: tb/tb_noc_vc_switch_allocator.sv
// Directed bench for noc_vc_switch_allocator: the stimulus process queues the
// expected {vc, flit} for each grant it predicts, and a negedge monitor pops
// and compares whenever out_valid is high.
module tb_noc_vc_switch_allocator;
    localparam int N     = 5;
    localparam int C     = 2;
    localparam int W     = 64;
    localparam int D     = 4;
    localparam int VC_W  = 1;
    localparam int CNT_W = 3;

    logic clk;
    logic rst;

    logic [N-1:0]      t_valid;
    logic [N*VC_W-1:0] t_vc;
    logic [N-1:0]      t_sop;
    logic [N-1:0]      t_eop;
    logic [N*W-1:0]    t_flit;
    logic [C-1:0]      t_ret;

    int total = 0;
    int bad   = 0;
    logic [VC_W+W-1:0] sb_q[$];
    logic [VC_W+W-1:0] mon_exp;

    int ord[6] = '{0, 2, 4, 0, 2, 4};
    int sq[N];

    noc_vc_switch_allocator_if #(.NUM_INPUTS(N), .CHANNELS(C), .FLIT_WIDTH(W),
                                 .CREDIT_DEPTH(D)) bus ();

    noc_vc_switch_allocator #(.NUM_INPUTS(N), .CHANNELS(C), .FLIT_WIDTH(W),
                              .CREDIT_DEPTH(D)) dut (
        .noc_clk (clk),
        .noc_rst (rst),
        .bus     (bus)
    );

    assign bus.in_valid      = t_valid;
    assign bus.in_vc         = t_vc;
    assign bus.in_sop        = t_sop;
    assign bus.in_eop        = t_eop;
    assign bus.in_flit       = t_flit;
    assign bus.credit_return = t_ret;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pay(int i, int s);
        return 64'hA5A5_0000_0000_0000 | (64'(i) << 8) | 64'(s);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_cnt(string name, int vc, int exp);
        check(name, 64'(bus.credit_count[vc*CNT_W +: CNT_W]), 64'(exp));
    endtask

    task automatic drive(int i, int vc, bit sop, bit eop, int seq);
        t_valid[i] = 1'b1;
        t_vc[i*VC_W +: VC_W] = VC_W'(vc);
        t_sop[i] = sop;
        t_eop[i] = eop;
        t_flit[i*W +: W] = pay(i, seq);
    endtask

    task automatic idle(int i);
        t_valid[i] = 1'b0;
        t_sop[i]   = 1'b0;
        t_eop[i]   = 1'b0;
    endtask

    task automatic idle_all();
        t_valid = '0;
        t_sop   = '0;
        t_eop   = '0;
        t_ret   = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks the combinational grant and queues the flit it should register.
    task automatic expect_grant(string name, int i, int vc, int seq);
        #1;
        check(name, 64'(bus.in_ready), 64'(1) << i);
        sb_q.push_back({VC_W'(vc), pay(i, seq)});
    endtask

    task automatic expect_none(string name);
        #1;
        check(name, 64'(bus.in_ready), 64'(0));
    endtask

    // Lets the monitor drain the last output, then pulses reset across one edge.
    task automatic do_reset();
        idle_all();
        @(posedge clk);
        #6;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected: got vc=%0d flit=%0h expected no output",
                         bus.out_vc, bus.out_flit);
            end else begin
                mon_exp = sb_q.pop_front();
                if ({bus.out_vc, bus.out_flit} !== mon_exp) begin
                    bad++;
                    $display("FAIL out_flit: got vc=%0d flit=%0h expected vc=%0d flit=%0h",
                             bus.out_vc, bus.out_flit, mon_exp[W +: VC_W], mon_exp[W-1:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        idle_all();
        t_vc   = '0;
        t_flit = '0;
        for (int i = 0; i < N; i++) sq[i] = 0;
        #1 rst = 1'b1;
        #2;
        // Reset state.
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_vc",    64'(bus.out_vc), 64'(0));
        check("rst_out_flit",  bus.out_flit, 64'(0));
        check("rst_in_ready",  64'(bus.in_ready), 64'(0));
        check("rst_credits",   64'(bus.credit_count), 64'h24);
        check("rst_locks",     64'(bus.vc_locked), 64'(0));
        check("rst_err_ovf",   64'(bus.err_credit_ovf), 64'(0));
        check("rst_err_proto", 64'(bus.err_protocol), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // Credit exhaustion: 6-flit packet on VC0 with no returns.
        drive(0, 0, 1, 0, 0);
        expect_grant("t1_g0", 0, 0, 0);
        step();
        for (int s = 1; s < 4; s++) begin
            drive(0, 0, 0, 0, s);
            expect_grant($sformatf("t1_g%0d", s), 0, 0, s);
            step();
        end
        drive(0, 0, 0, 0, 4);
        expect_none("t1_stall");
        check_cnt("t1_cnt_zero", 0, 0);
        step();
        t_ret[0] = 1'b1;
        expect_none("t1_stall_on_return");
        step();
        t_ret[0] = 1'b0;
        check_cnt("t1_cnt_one", 0, 1);
        expect_grant("t1_g4", 0, 0, 4);
        step();
        drive(0, 0, 0, 1, 5);
        expect_none("t1_stall_tail");
        check("t1_lock_held", 64'(bus.vc_locked), 64'h1);
        do_reset();

        // Fairness: single-flit packets from inputs 0, 2, 4 with credits replenished.
        drive(0, 0, 1, 1, 0);
        drive(2, 0, 1, 1, 0);
        drive(4, 0, 1, 1, 0);
        t_ret[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            expect_grant($sformatf("t2_g%0d", k), ord[k], 0, sq[ord[k]]);
            step();
            sq[ord[k]]++;
            drive(ord[k], 0, 1, 1, sq[ord[k]]);
        end
        idle_all();
        check_cnt("t2_cnt", 0, 4);
        check("t2_no_ovf", 64'(bus.err_credit_ovf), 64'(0));
        do_reset();

        // Wormhole lock: input 3's VC1 head waits behind input 1's packet.
        drive(1, 1, 1, 0, 0);
        expect_grant("t3_head", 1, 1, 0);
        step();
        check("t3_lock_head", 64'(bus.vc_locked), 64'h2);
        drive(1, 1, 0, 0, 1);
        drive(3, 1, 1, 1, 0);
        expect_grant("t3_body", 1, 1, 1);
        step();
        check("t3_lock_body", 64'(bus.vc_locked), 64'h2);
        drive(1, 1, 0, 1, 2);
        expect_grant("t3_tail", 1, 1, 2);
        step();
        idle(1);
        check("t3_lock_free", 64'(bus.vc_locked), 64'h0);
        expect_grant("t3_in3", 3, 1, 0);
        step();
        idle(3);
        check("t3_lock_after", 64'(bus.vc_locked), 64'h0);
        check_cnt("t3_cnt_vc1", 1, 0);
        check("t3_no_proto", 64'(bus.err_protocol), 64'(0));
        do_reset();

        // VC interleave: inputs 0 (VC0) and 1 (VC1) alternate.
        drive(0, 0, 1, 0, 0);
        drive(1, 1, 1, 0, 0);
        expect_grant("t4_g0", 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 1);
        expect_grant("t4_g1", 1, 1, 0);
        step();
        drive(1, 1, 0, 0, 1);
        check("t4_both_locked", 64'(bus.vc_locked), 64'h3);
        expect_grant("t4_g2", 0, 0, 1);
        step();
        drive(0, 0, 0, 1, 2);
        expect_grant("t4_g3", 1, 1, 1);
        step();
        drive(1, 1, 0, 1, 2);
        expect_grant("t4_g4", 0, 0, 2);
        step();
        idle(0);
        check("t4_vc0_free", 64'(bus.vc_locked), 64'h2);
        expect_grant("t4_g5", 1, 1, 2);
        step();
        idle(1);
        check("t4_locks_clear", 64'(bus.vc_locked), 64'h0);
        check("t4_credits", 64'(bus.credit_count), 64'h09);
        do_reset();

        // Simultaneous grant and return at credit 2, then overflow at full.
        drive(2, 0, 1, 1, 0);
        expect_grant("t5_g0", 2, 0, 0);
        step();
        drive(2, 0, 1, 1, 1);
        expect_grant("t5_g1", 2, 0, 1);
        step();
        drive(2, 0, 1, 1, 2);
        check_cnt("t5_cnt_two", 0, 2);
        t_ret[0] = 1'b1;
        expect_grant("t5_g2", 2, 0, 2);
        step();
        idle(2);
        check_cnt("t5_cnt_same", 0, 2);
        step();
        check_cnt("t5_cnt_three", 0, 3);
        step();
        check_cnt("t5_cnt_full", 0, 4);
        check("t6_ovf_before", 64'(bus.err_credit_ovf), 64'(0));
        step();
        t_ret[0] = 1'b0;
        check_cnt("t6_cnt_stays", 0, 4);
        check("t6_ovf_set", 64'(bus.err_credit_ovf), 64'(1));
        check_cnt("t6_cnt_vc1", 1, 4);

        // Body flit on an unlocked VC is held back and flagged.
        check("t7_proto_before", 64'(bus.err_protocol), 64'(0));
        drive(3, 1, 0, 0, 0);
        expect_none("t7_no_grant");
        step();
        idle(3);
        check("t7_proto_set", 64'(bus.err_protocol), 64'(1));
        step();
        check("t7_proto_sticky", 64'(bus.err_protocol), 64'(1));
        do_reset();

        // Reset in the middle of a 4-flit VC1 packet.
        drive(4, 1, 1, 0, 0);
        expect_grant("t8_g0", 4, 1, 0);
        step();
        drive(4, 1, 0, 0, 1);
        expect_grant("t8_g1", 4, 1, 1);
        step();
        drive(4, 1, 0, 0, 2);
        #1;
        check("t8_flit2_offered", 64'(bus.in_ready), 64'h10);
        #4;
        rst = 1'b1;
        #1;
        check("t8_rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("t8_rst_out_flit",  bus.out_flit, 64'(0));
        check("t8_rst_out_vc",    64'(bus.out_vc), 64'(0));
        check("t8_rst_locks",     64'(bus.vc_locked), 64'(0));
        check("t8_rst_credits",   64'(bus.credit_count), 64'h24);
        check("t8_rst_in_ready",  64'(bus.in_ready), 64'(0));
        idle_all();
        @(posedge clk);
        #1 rst = 1'b0;
        drive(4, 1, 1, 1, 9);
        expect_grant("t8_new_head", 4, 1, 9);
        step();
        idle_all();
        check_cnt("t8_cnt_vc1", 1, 3);
        check("t8_lock_after", 64'(bus.vc_locked), 64'(0));

        step();
        step();
        check("sb_drain", 64'(sb_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/noc_vc_switch_allocator.md
Name: noc_vc_switch_allocator

Overview:
- Per-output-port switch/VC allocator with a registered crossbar output stage, for the next-generation router.
- Arbitrates NUM_INPUTS input blocks onto one output link and keeps wormhole packet ownership per virtual channel, so packets on different VCs may interleave.
- Tracks downstream buffer space with per-VC credit counters.
- One instance sits in front of every router output port, local port included.

Parameters:
- NUM_INPUTS, 5, number of requesting input blocks (≥2).
- CHANNELS, 2, virtual channels per link (≥1).
- FLIT_WIDTH, 64, flit payload width.
- CREDIT_DEPTH, 4, downstream buffer depth per VC; credit reset value (≥1).
- VC_W, $clog2(CHANNELS) (min 1), derived VC index width.
- CNT_W, $clog2(CREDIT_DEPTH+1), derived credit counter width.

Ports:
- noc_clk  in  1  clock.
- noc_rst  in  1  reset, asynchronous, active-high.
- in_valid  in  NUM_INPUTS  input i presents a flit.
- in_vc  in  NUM_INPUTS*VC_W  target VC of input i's flit.
- in_sop  in  NUM_INPUTS  flit is head.
- in_eop  in  NUM_INPUTS  flit is tail.
- in_flit  in  NUM_INPUTS*FLIT_WIDTH  flit payloads, input i at slice i.
- in_ready  out  NUM_INPUTS  one-hot grant; flit consumed this cycle.
- out_valid  out  1  registered flit valid.
- out_vc  out  VC_W  VC of out_flit.
- out_flit  out  FLIT_WIDTH  registered flit.
- credit_return  in  CHANNELS  per-VC one-cycle credit pulse from downstream.
- credit_count  out  CHANNELS*CNT_W  current credits per VC.
- vc_locked  out  CHANNELS  VC owned by an in-flight packet.
- err_credit_ovf  out  1  sticky: credit returned while counter already at CREDIT_DEPTH.
- err_protocol  out  1  sticky: owner input presented in_sop while holding its VC, or body/tail flit on an unlocked VC.

Behaviour:
- Reset values:
  - out_valid=0, out_vc=0, out_flit=0, in_ready=0.
  - All credits=CREDIT_DEPTH, all locks clear, owners=0, rr pointer=0.
  - Both error flags 0.
- Per-VC lock states: IDLE, LOCKED(owner).
  - IDLE→LOCKED(i) on grant of input i with sop=1, eop=0.
  - LOCKED→IDLE on grant of the owner with eop=1.
  - A grant with sop=1 and eop=1 leaves the VC IDLE.
- Eligibility of input i (v=in_vc[i]): in_valid[i] && credit[v]>0, and one of:
  - in_sop[i] && vc IDLE, or
  - !in_sop[i] && LOCKED(i).
- Ineligible inputs wait; in_ready stays 0. Protocol violations set err_protocol.
- Arbitration:
  - Combinational round-robin over eligible inputs, searching from the rr pointer upward with wrap.
  - At most one grant per cycle; in_ready is one-hot or zero.
  - On grant g, the pointer becomes (g+1) mod NUM_INPUTS. With no grant, the pointer holds.
- Datapath: on grant, out_flit/out_vc/out_valid register in_flit[g]/in_vc[g]/1 at the next edge (latency 1 cycle). With no grant, out_valid=0 next cycle and out_flit holds its value.
- No output backpressure; flow control is credit-only.
- Credits, per VC, each cycle:
  - Grant on v and no return: decrement.
  - Return on v and no grant: increment.
  - Grant and return on v together: unchanged.
  - Return with counter at CREDIT_DEPTH and no grant: counter stays, err_credit_ovf set.
- Counters never underflow, because eligibility requires credit>0.
- A return and a grant in the same cycle do not let a zero-credit VC win; eligibility uses the current registered count.
- Reset mid-packet: locks and credits reinitialise immediately (asynchronous). The partial packet is abandoned and the upstream must also be reset.
- Error flags clear only on reset.

Test Plan:
- Credit exhaustion: CREDIT_DEPTH=4, input 0 streams a 6-flit packet on VC0, no returns → exactly 4 grants, then in_ready[0]=0 and credit_count[VC0]=0. One credit_return[0] pulse → 1 further grant the next cycle.
- Fairness: inputs 0, 2, 4 send single-flit packets (sop=eop=1) on VC0, credits replenished each cycle → grant order 0, 2, 4, 0, 2, 4. out_flit is each payload one cycle after its grant.
- Wormhole lock: input 1 sends a 3-flit VC1 packet, input 3 raises a VC1 head at cycle 1 → input 3 is granted only after input 1's tail. vc_locked[1]=1 from the cycle after input 1's head to the cycle after its tail.
- VC interleave: input 0 sends on VC0 and input 1 on VC1, both multi-flit → grants alternate 0, 1, 0, 1. out_vc toggles and both locks are held simultaneously.
- Simultaneous credit return and grant on VC0 with credit=2 → credit stays 2.
- Return when credit=4 → stays 4, err_credit_ovf=1.
- Reset mid-packet: assert noc_rst during flit 2 of a 4-flit packet → outputs 0, vc_locked=0 and credits=CREDIT_DEPTH asynchronously. A new head on the same VC is granted after release.
